// File: rtl/mh2bin_seq_pkg.sv
// Shared definitions for the multi-hot to binary encoder slice.
// Index widths are derived here so the interface and all modules agree on them.
package mh2bin_seq_pkg;

  // A 1-wide vector still needs a 1-bit index port.
  function automatic int clog2_safe(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mh2bin_seq_if.sv
// Vector-in / index-out stream bundle for mh2bin_seq.
// The slave modport is the encoder; the master modport is the producer/consumer side.
interface mh2bin_seq_if
  import mh2bin_seq_pkg::*;
#(
  parameter int VEC_WIDTH = 32,
  parameter int BIN_WIDTH = clog2_safe(VEC_WIDTH)
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [VEC_WIDTH-1:0] in_vec_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [BIN_WIDTH-1:0] out_idx_o;
  logic [VEC_WIDTH-1:0] out_oh_o;
  logic                 out_last_o;

  modport slave (
    input  in_valid_i, in_vec_i, out_ready_i,
    output in_ready_o, out_valid_o, out_idx_o, out_oh_o, out_last_o
  );

  modport master (
    output in_valid_i, in_vec_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_idx_o, out_oh_o, out_last_o
  );
endinterface

// File: rtl/mh2bin_seq_prio_enc_rr.sv
// Combinational find-first-set starting at an offset, wrapping modulo VEC_WIDTH.
// Rotates the vector down by start_i, finds the lowest set bit, then adds the offset back.
module prio_enc_rr
  import mh2bin_seq_pkg::*;
#(
  parameter int VEC_WIDTH = 32,
  parameter int BIN_WIDTH = clog2_safe(VEC_WIDTH)
) (
  input  logic [VEC_WIDTH-1:0] vec_i,
  input  logic [BIN_WIDTH-1:0] start_i,
  output logic [BIN_WIDTH-1:0] idx_o,
  output logic [VEC_WIDTH-1:0] oh_o,
  output logic                 found_o
);

  localparam logic [BIN_WIDTH:0] VW_W = (BIN_WIDTH+1)'(VEC_WIDTH);

  logic [VEC_WIDTH-1:0] rot;
  logic [BIN_WIDTH-1:0] off;
  logic [BIN_WIDTH:0]   sum;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    rot     = VEC_WIDTH'({vec_i, vec_i} >> start_i);
    off     = '0;
    found_o = |vec_i;
    for (int i = VEC_WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) off = BIN_WIDTH'(i);
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= VW_W) sum = sum - VW_W;
    idx_o = found_o ? sum[BIN_WIDTH-1:0] : '0;
    oh_o  = found_o ? (VEC_WIDTH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mh2bin_seq.sv
// Sequential multi-hot to binary encoder: loads a vector, then streams the index
// of each set bit, lowest-first or round-robin from the last emitted index.
module mh2bin_seq
  import mh2bin_seq_pkg::*;
#(
  parameter int VEC_WIDTH = 32,
  parameter int BIN_WIDTH = clog2_safe(VEC_WIDTH),
  parameter int RR_EN     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  mh2bin_seq_if.slave bus,
  output logic        zero_drop_o,
  output logic        busy_o
);

  logic [VEC_WIDTH-1:0] mask_q, mask_d;
  logic [BIN_WIDTH-1:0] ptr_q, ptr_d;
  logic                 zero_drop_q, zero_drop_d;

  logic [BIN_WIDTH-1:0] start;
  logic [BIN_WIDTH-1:0] sel_idx;
  logic [VEC_WIDTH-1:0] sel_oh;
  logic                 sel_found;
  logic                 out_fire;
  logic                 in_fire;

  assign start = (RR_EN != 0) ? ptr_q : '0;

  prio_enc_rr #(
    .VEC_WIDTH (VEC_WIDTH),
    .BIN_WIDTH (BIN_WIDTH)
  ) u_enc (
    .vec_i   (mask_q),
    .start_i (start),
    .idx_o   (sel_idx),
    .oh_o    (sel_oh),
    .found_o (sel_found)
  );

  // Outputs depend only on registered state, so the consumer sees no input-to-output path.
  assign bus.out_valid_o = sel_found;
  assign bus.out_idx_o   = sel_idx;
  assign bus.out_oh_o    = sel_oh;
  assign bus.out_last_o  = sel_found & ((mask_q & (mask_q - VEC_WIDTH'(1))) == '0);

  assign out_fire       = bus.out_valid_o & bus.out_ready_i;
  assign bus.in_ready_o = ~flush_i & (~bus.out_valid_o | (out_fire & bus.out_last_o));
  assign in_fire        = bus.in_valid_i & bus.in_ready_o;

  assign zero_drop_o = zero_drop_q;
  assign busy_o      = |mask_q;

  always_comb begin
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    zero_drop_d = 1'b0;
    if (out_fire) begin
      mask_d = mask_q & ~sel_oh;
      if (RR_EN != 0) begin
        ptr_d = (sel_idx == BIN_WIDTH'(VEC_WIDTH - 1)) ? '0 : sel_idx + BIN_WIDTH'(1);
      end
    end
    if (flush_i) mask_d = '0;
    // A new vector overwrites whatever the last beat left behind; ptr still follows that beat.
    if (in_fire) begin
      mask_d      = bus.in_vec_i;
      zero_drop_d = ~|bus.in_vec_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      ptr_q       <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      zero_drop_q <= zero_drop_d;
    end
  end

endmodule

// File: tb/tb_mh2bin_seq.sv
// Scoreboard bench for mh2bin_seq: three instances (8-bit lowest-first, 8-bit RR, 32-bit RR)
// driven one at a time; expected beats are queued at load time and checked as beats leave.
module tb_mh2bin_seq;
  import mh2bin_seq_pkg::*;

  localparam int WIDTH_C [3] = '{8, 8, 32};
  localparam int RR_C    [3] = '{0, 1, 1};

  typedef struct {
    int   dut;
    int   idx;
    logic last;
  } beat_t;

  logic clk;
  logic rst_n;

  logic        in_valid_a  [3];
  logic [31:0] in_vec_a    [3];
  logic        out_ready_a [3];
  logic        flush_a     [3];

  logic        vld_w  [3];
  logic        rdy_w  [3];
  logic [4:0]  idx_w  [3];
  logic [31:0] oh_w   [3];
  logic        last_w [3];
  logic        zd_w   [3];
  logic        busy_w [3];

  beat_t exp_q[$];
  int    ptr_m [3];
  int    total;
  int    bad;

  mh2bin_seq_if #(.VEC_WIDTH(8))  if0 ();
  mh2bin_seq_if #(.VEC_WIDTH(8))  if1 ();
  mh2bin_seq_if #(.VEC_WIDTH(32)) if2 ();

  assign if0.in_valid_i  = in_valid_a[0];
  assign if0.in_vec_i    = in_vec_a[0][7:0];
  assign if0.out_ready_i = out_ready_a[0];
  assign if1.in_valid_i  = in_valid_a[1];
  assign if1.in_vec_i    = in_vec_a[1][7:0];
  assign if1.out_ready_i = out_ready_a[1];
  assign if2.in_valid_i  = in_valid_a[2];
  assign if2.in_vec_i    = in_vec_a[2];
  assign if2.out_ready_i = out_ready_a[2];

  assign vld_w[0]  = if0.out_valid_o;
  assign rdy_w[0]  = if0.in_ready_o;
  assign idx_w[0]  = {2'b0, if0.out_idx_o};
  assign oh_w[0]   = {24'b0, if0.out_oh_o};
  assign last_w[0] = if0.out_last_o;
  assign vld_w[1]  = if1.out_valid_o;
  assign rdy_w[1]  = if1.in_ready_o;
  assign idx_w[1]  = {2'b0, if1.out_idx_o};
  assign oh_w[1]   = {24'b0, if1.out_oh_o};
  assign last_w[1] = if1.out_last_o;
  assign vld_w[2]  = if2.out_valid_o;
  assign rdy_w[2]  = if2.in_ready_o;
  assign idx_w[2]  = if2.out_idx_o;
  assign oh_w[2]   = if2.out_oh_o;
  assign last_w[2] = if2.out_last_o;

  mh2bin_seq #(.VEC_WIDTH(8), .RR_EN(0)) u_lo8 (
    .clk (clk), .rst_n (rst_n), .flush_i (flush_a[0]), .bus (if0.slave),
    .zero_drop_o (zd_w[0]), .busy_o (busy_w[0])
  );
  mh2bin_seq #(.VEC_WIDTH(8), .RR_EN(1)) u_rr8 (
    .clk (clk), .rst_n (rst_n), .flush_i (flush_a[1]), .bus (if1.slave),
    .zero_drop_o (zd_w[1]), .busy_o (busy_w[1])
  );
  mh2bin_seq #(.VEC_WIDTH(32), .RR_EN(1)) u_rr32 (
    .clk (clk), .rst_n (rst_n), .flush_i (flush_a[2]), .bus (if2.slave),
    .zero_drop_o (zd_w[2]), .busy_o (busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference order: plain scan from the start point, independent of how the RTL rotates.
  function automatic void model_push(input int d, input logic [31:0] v);
    int          w;
    int          p;
    logic [31:0] m;
    beat_t       b;
    w = WIDTH_C[d];
    p = ptr_m[d];
    m = v;
    while (m != 0) begin
      int k;
      int sel;
      k   = (RR_C[d] != 0) ? p : 0;
      sel = -1;
      for (int j = 0; j < w; j++) begin
        if (sel < 0 && m[(k + j) % w]) sel = (k + j) % w;
      end
      m[sel] = 1'b0;
      b.dut  = d;
      b.idx  = sel;
      b.last = (m == 0);
      exp_q.push_back(b);
      if (RR_C[d] != 0) p = (sel + 1) % w;
    end
    ptr_m[d] = p;
  endfunction

  // Called at posedge+1; leaves the vector accepted and returns at the following posedge+1.
  task automatic send(input int d, input logic [31:0] v);
    int n;
    n = 0;
    while (!rdy_w[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_load", 32'(rdy_w[d]), 1);
    in_valid_a[d] = 1'b1;
    in_vec_a[d]   = v;
    model_push(d, v);
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int exp_n, input string tag);
    int n;
    n = 0;
    while (vld_w[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, exp_n);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst_n && vld_w[d] && out_ready_a[d]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(d), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_dut", d, e.dut);
          check("beat_idx", 32'(idx_w[d]), e.idx);
          check("beat_oh", oh_w[d], 32'd1 << e.idx);
          check("beat_last", 32'(last_w[d]), 32'(e.last));
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      in_vec_a[d]    = '0;
      out_ready_a[d] = 1'b1;
      flush_a[d]     = 1'b0;
      ptr_m[d]       = 0;
    end

    // Reset values
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 32'(rdy_w[d]), 1);
      check("rst_out_valid", 32'(vld_w[d]), 0);
      check("rst_busy", 32'(busy_w[d]), 0);
      check("rst_zero_drop", 32'(zd_w[d]), 0);
    end
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Lowest-first: 1,2,5,7 in four back-to-back beats
    send(0, 32'hA6);
    check("lat1_valid", 32'(vld_w[0]), 1);
    check("lat1_idx", 32'(idx_w[0]), 1);
    check("busy_loaded", 32'(busy_w[0]), 1);
    drain(0, 4, "lo_a6_cycles");

    // Back-pressure on idx 2 for three cycles
    out_ready_a[0] = 1'b0;
    send(0, 32'h26);
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_idx", 32'(idx_w[0]), 2);
      check("stall_oh", oh_w[0], 32'h04);
      check("stall_last", 32'(last_w[0]), 0);
    end
    @(posedge clk); #1;
    out_ready_a[0] = 1'b1;
    drain(0, 2, "stall_drain");

    // Back-to-back: 8'h81 presented during the last beat of 8'h06
    send(0, 32'h06);
    @(posedge clk); #1;
    check("b2b_last_beat", 32'(last_w[0]), 1);
    check("b2b_in_ready", 32'(rdy_w[0]), 1);
    in_valid_a[0] = 1'b1;
    in_vec_a[0]   = 32'h81;
    model_push(0, 32'h81);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    check("b2b_no_bubble", 32'(vld_w[0]), 1);
    check("b2b_first_idx", 32'(idx_w[0]), 0);
    drain(0, 2, "b2b_drain");

    // All-zero vector is dropped with a one-cycle pulse
    send(0, 32'h00);
    check("zero_drop_pulse", 32'(zd_w[0]), 1);
    check("zero_no_beat", 32'(vld_w[0]), 0);
    check("zero_not_busy", 32'(busy_w[0]), 0);
    @(posedge clk); #1;
    check("zero_drop_clear", 32'(zd_w[0]), 0);

    // Flush mid-vector while a new vector is offered
    out_ready_a[0] = 1'b0;
    send(0, 32'hF0);
    flush_a[0]    = 1'b1;
    in_valid_a[0] = 1'b1;
    in_vec_a[0]   = 32'h0F;
    #1;
    check("flush_in_ready", 32'(rdy_w[0]), 0);
    @(posedge clk); #1;
    flush_a[0]    = 1'b0;
    in_valid_a[0] = 1'b0;
    exp_q.delete();
    check("flush_cleared", 32'(vld_w[0]), 0);
    check("flush_not_busy", 32'(busy_w[0]), 0);
    @(posedge clk); #1;
    check("flush_no_load", 32'(vld_w[0]), 0);
    out_ready_a[0] = 1'b1;

    // Async reset in the middle of a stalled vector
    out_ready_a[1] = 1'b0;
    send(1, 32'hFF);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(vld_w[1]), 0);
    check("arst_in_ready", 32'(rdy_w[1]), 1);
    check("arst_busy", 32'(busy_w[1]), 0);
    check("arst_idx", 32'(idx_w[1]), 0);
    check("arst_oh", oh_w[1], 0);
    check("arst_last", 32'(last_w[1]), 0);
    exp_q.delete();
    for (int d = 0; d < 3; d++) ptr_m[d] = 0;
    @(negedge clk);
    rst_n          = 1'b1;
    out_ready_a[1] = 1'b1;
    @(posedge clk); #1;

    // Round-robin: steer ptr to 6, then 6,0,2 and 3,0
    send(1, 32'h20);
    drain(1, 1, "rr_prime");
    send(1, 32'h45);
    check("rr_first_idx", 32'(idx_w[1]), 6);
    drain(1, 3, "rr_45_cycles");
    send(1, 32'h09);
    check("rr_ptr_carry", 32'(idx_w[1]), 3);
    drain(1, 2, "rr_09_cycles");

    // 32-bit all ones with round-robin wrap from 20
    send(2, 32'h0008_0000);
    drain(2, 1, "rr32_prime");
    send(2, 32'hFFFF_FFFF);
    check("rr32_first_idx", 32'(idx_w[2]), 20);
    drain(2, 32, "rr32_cycles");

    @(posedge clk); #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
